// File: rtl/ddr3_amm_pkg.sv
// Shared widths, burst limit and FSM encoding for the
// DDR3 Avalon-MM burst master.
package ddr3_amm_pkg;

    localparam int ADDR_W    = 23;
    localparam int DATA_W    = 320;
    localparam int BURST_W   = 7;
    localparam int BE_W      = DATA_W / 8;
    localparam int MAX_BURST = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_REQ   = 2'd2
    } amm_state_t;

endpackage

// File: rtl/ddr3_rd_credit.sv
// Outstanding read-beat counter: adds a burst length on issue,
// subtracts one per returned beat, never wraps below zero.
module ddr3_rd_credit #(
    parameter int RD_CREDITS = 128,
    parameter int BURST_W    = 7,
    parameter int CW         = $clog2(RD_CREDITS) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_add,
    input  logic [BURST_W-1:0] i_add_len,
    input  logic               i_sub,
    output logic [CW-1:0]      o_outstanding,
    output logic [CW-1:0]      o_credits_free
);
    import ddr3_amm_pkg::*;

    localparam logic [CW-1:0] FULL = CW'(RD_CREDITS);

    logic [CW-1:0] r_out;
    logic [CW-1:0] w_sum;
    logic [CW-1:0] w_next;

    // Next count: add issued length, then take one returned beat
    always_comb begin
        w_sum = r_out;
        if (i_add) begin
            w_sum = r_out + CW'(i_add_len);
        end
        w_next = w_sum;
        if (i_sub && (w_sum != '0)) begin
            w_next = w_sum - CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            r_out <= w_next;
        end
    end

    // A returned beat with nothing outstanding means the EMIF misbehaved
    always @(posedge clk) begin
        if (!rst && i_sub) begin
            assert (r_out != '0);
        end
    end

    assign o_outstanding  = r_out;
    assign o_credits_free = FULL - r_out;

endmodule

// File: rtl/ddr3_amm_burst_master.sv
// Avalon-MM burst master for the DDR3 EMIF ctrl_amm_0 port:
// write bursts stream through, reads are gated by credits.
module ddr3_amm_burst_master #(
    parameter int ADDR_W     = ddr3_amm_pkg::ADDR_W,
    parameter int DATA_W     = ddr3_amm_pkg::DATA_W,
    parameter int BURST_W    = ddr3_amm_pkg::BURST_W,
    parameter int MAX_BURST  = ddr3_amm_pkg::MAX_BURST,
    parameter int RD_CREDITS = 128
) (
    input  logic                emif_usr_clk,
    input  logic                emif_usr_rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [BURST_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                cmd_err,
    output logic                busy,
    input  logic                amm_ready_0,
    output logic                amm_read_0,
    output logic                amm_write_0,
    output logic [ADDR_W-1:0]   amm_address_0,
    output logic [BURST_W-1:0]  amm_burstcount_0,
    output logic [DATA_W-1:0]   amm_writedata_0,
    output logic [DATA_W/8-1:0] amm_byteenable_0,
    input  logic [DATA_W-1:0]   amm_readdata_0,
    input  logic                amm_readdatavalid_0
);
    import ddr3_amm_pkg::*;

    localparam int CW = $clog2(RD_CREDITS) + 1;
    localparam logic [BURST_W-1:0] MAX_LEN = BURST_W'(MAX_BURST);

    amm_state_t         r_state;
    logic               r_live;
    logic               r_cmd_err;
    logic               r_rd_valid;
    logic [DATA_W-1:0]  r_rd_data;
    logic [ADDR_W-1:0]  r_addr;
    logic [BURST_W-1:0] r_len;
    logic [BURST_W-1:0] r_left;

    logic [CW-1:0] w_outstanding;
    logic [CW-1:0] w_credits_free;
    logic          w_fits;
    logic          w_legal;
    logic          w_fire;
    logic          w_beat;
    logic          w_rd_go;

    assign w_fits  = {{BURST_W{1'b0}}, w_credits_free}
                     >= {{CW{1'b0}}, cmd_len};
    assign w_legal = (cmd_len != '0) && (cmd_len <= MAX_LEN);

    assign cmd_ready = r_live && (r_state == IDLE)
                       && (cmd_write || w_fits);
    assign w_fire    = cmd_valid && cmd_ready;
    assign w_beat    = (r_state == WR_BURST) && wr_valid && amm_ready_0;
    assign w_rd_go   = (r_state == RD_REQ) && amm_ready_0;

    // Command acceptance and burst sequencing
    always_ff @(posedge emif_usr_clk or posedge emif_usr_rst) begin
        if (emif_usr_rst) begin
            r_state   <= IDLE;
            r_live    <= 1'b0;
            r_cmd_err <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_left    <= '0;
        end else begin
            r_live    <= 1'b1;
            r_cmd_err <= w_fire && !w_legal;
            unique case (r_state)
                IDLE: begin
                    if (w_fire && w_legal) begin
                        r_addr  <= cmd_addr;
                        r_len   <= cmd_len;
                        r_left  <= cmd_len;
                        r_state <= cmd_write ? WR_BURST : RD_REQ;
                    end
                end
                WR_BURST: begin
                    if (w_beat) begin
                        r_left <= r_left - BURST_W'(1);
                        if (r_left == BURST_W'(1)) begin
                            r_state <= IDLE;
                        end
                    end
                end
                RD_REQ: begin
                    if (amm_ready_0) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read return path, one register stage
    always_ff @(posedge emif_usr_clk or posedge emif_usr_rst) begin
        if (emif_usr_rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= amm_readdatavalid_0;
            r_rd_data  <= amm_readdata_0;
        end
    end

    ddr3_rd_credit #(
        .RD_CREDITS (RD_CREDITS),
        .BURST_W    (BURST_W),
        .CW         (CW)
    ) u_credit (
        .clk            (emif_usr_clk),
        .rst            (emif_usr_rst),
        .i_add          (w_rd_go),
        .i_add_len      (r_len),
        .i_sub          (amm_readdatavalid_0),
        .o_outstanding  (w_outstanding),
        .o_credits_free (w_credits_free)
    );

    assign amm_read_0       = (r_state == RD_REQ);
    assign amm_write_0      = (r_state == WR_BURST) && wr_valid;
    assign wr_ready         = (r_state == WR_BURST) && amm_ready_0;
    assign amm_address_0    = r_addr;
    assign amm_burstcount_0 = r_len;
    assign amm_writedata_0  = wr_data;
    assign amm_byteenable_0 = '1;
    assign rd_valid         = r_rd_valid;
    assign rd_data          = r_rd_data;
    assign cmd_err          = r_cmd_err;
    assign busy             = (r_state != IDLE) || (w_outstanding != '0);

endmodule

// File: tb/tb_ddr3_amm_burst_master.sv
// Randomised bench for ddr3_amm_burst_master with a transaction-level
// reference model and an EMIF responder.
module tb_ddr3_amm_burst_master;

    localparam int AW  = 23;
    localparam int DW  = 320;
    localparam int BW  = 7;
    localparam int BEW = DW / 8;
    localparam int CRED = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [BW-1:0] cmd_len = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          amm_ready_0 = 1'b0;
    logic          amm_readdatavalid_0 = 1'b0;
    logic [DW-1:0] amm_readdata_0 = '0;

    logic           cmd_ready, wr_ready, rd_valid, cmd_err, busy;
    logic [DW-1:0]  rd_data, amm_writedata_0;
    logic           amm_read_0, amm_write_0;
    logic [AW-1:0]  amm_address_0;
    logic [BW-1:0]  amm_burstcount_0;
    logic [BEW-1:0] amm_byteenable_0;

    ddr3_amm_burst_master dut (
        .emif_usr_clk        (clk),
        .emif_usr_rst        (rst),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_write           (cmd_write),
        .cmd_addr            (cmd_addr),
        .cmd_len             (cmd_len),
        .wr_data             (wr_data),
        .wr_valid            (wr_valid),
        .wr_ready            (wr_ready),
        .rd_data             (rd_data),
        .rd_valid            (rd_valid),
        .cmd_err             (cmd_err),
        .busy                (busy),
        .amm_ready_0         (amm_ready_0),
        .amm_read_0          (amm_read_0),
        .amm_write_0         (amm_write_0),
        .amm_address_0       (amm_address_0),
        .amm_burstcount_0    (amm_burstcount_0),
        .amm_writedata_0     (amm_writedata_0),
        .amm_byteenable_0    (amm_byteenable_0),
        .amm_readdata_0      (amm_readdata_0),
        .amm_readdatavalid_0 (amm_readdatavalid_0)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [DW-1:0] act,
                        input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    // reference model: mode 0 idle, 1 write burst, 2 read request
    int            m_mode = 0;
    int            m_left = 0;
    logic [AW-1:0] m_addr = '0;
    logic [BW-1:0] m_len = '0;
    int            m_out = 0;
    bit            m_err = 0;
    bit            m_armed = 0;
    bit            p_rdv = 0;
    logic [DW-1:0] p_rdd = '0;
    int            pending = 0;
    logic [DW-1:0] wq[$];
    int cnt_wbeat = 0, cnt_rdv = 0, cnt_err = 0, cnt_req = 0;

    // EMIF responder controls
    int  rdy_pct = 100;
    bit  ret_en = 1;
    bit  rdy_script[$];
    bit  n_rdy = 0, n_rdv = 0;
    logic [DW-1:0] n_rdd = '0;

    bit fire, legal, exp_rdy;

    always @(negedge clk) begin
        if (rst) begin
            chk1("rst_read", amm_read_0, 1'b0);
            chk1("rst_write", amm_write_0, 1'b0);
            chk1("rst_rd_valid", rd_valid, 1'b0);
            chk1("rst_cmd_err", cmd_err, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_cmd_ready", cmd_ready, 1'b0);
            chkv("rst_addr", DW'(amm_address_0), '0);
            chkv("rst_bcount", DW'(amm_burstcount_0), '0);
            m_mode = 0; m_left = 0; m_addr = '0; m_len = '0;
            m_out = 0; m_err = 0; m_armed = 0; p_rdv = 0;
            pending = 0; n_rdy = 0; n_rdv = 0;
            wq.delete();
        end else begin
            exp_rdy = m_armed && (m_mode == 0) &&
                      (cmd_write || (CRED - m_out) >= int'(cmd_len));
            chk1("cmd_ready", cmd_ready, exp_rdy);
            chk1("amm_read", amm_read_0, m_mode == 2);
            chk1("amm_write", amm_write_0, (m_mode == 1) && wr_valid);
            chk1("wr_ready", wr_ready, (m_mode == 1) && amm_ready_0);
            chk1("rw_excl", amm_read_0 && amm_write_0, 1'b0);
            chk1("byteen", &amm_byteenable_0, 1'b1);
            chkv("addr", DW'(amm_address_0), DW'(m_addr));
            chkv("bcount", DW'(amm_burstcount_0), DW'(m_len));
            chk1("busy", busy, (m_mode != 0) || (m_out != 0));
            chk1("cmd_err", cmd_err, m_err);
            chk1("rd_valid", rd_valid, p_rdv);
            if (p_rdv) chkv("rd_data", rd_data, p_rdd);
            if (amm_read_0 || amm_write_0) cnt_req++;
            if (rd_valid) cnt_rdv++;
            if (cmd_err) cnt_err++;
            fire  = cmd_valid && exp_rdy;
            legal = (cmd_len != 0) && (cmd_len <= 64);
            m_err = fire && !legal;
            case (m_mode)
                0: if (fire && legal) begin
                    m_addr = cmd_addr;
                    m_len  = cmd_len;
                    m_left = int'(cmd_len);
                    m_mode = cmd_write ? 1 : 2;
                end
                1: if (wr_valid && amm_ready_0) begin
                    if (wq.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL wbeat_extra: beat with none pending");
                    end else begin
                        chkv("wdata", amm_writedata_0, wq.pop_front());
                    end
                    cnt_wbeat++;
                    m_left--;
                    if (m_left == 0) m_mode = 0;
                end
                default: if (amm_ready_0) begin
                    m_out   += int'(m_len);
                    pending += int'(m_len);
                    m_mode   = 0;
                end
            endcase
            if (amm_readdatavalid_0) m_out--;
            p_rdv   = amm_readdatavalid_0;
            p_rdd   = amm_readdata_0;
            m_armed = 1;
            if (rdy_script.size() > 0) n_rdy = rdy_script.pop_front();
            else n_rdy = ($urandom_range(99) < rdy_pct);
            n_rdv = 0;
            if (ret_en && pending > 0 && $urandom_range(3) != 0) begin
                n_rdv = 1;
                n_rdd = rnd_data();
                pending--;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        amm_ready_0 = n_rdy;
        amm_readdatavalid_0 = n_rdv;
        amm_readdata_0 = n_rdd;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input bit w, input logic [AW-1:0] a,
                            input int len);
        bit ok = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = BW'(len);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        cycle();
        cmd_valid = 0;
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL cmd_timeout: len %0d not accepted", len);
        end
    endtask

    task automatic wr_burst(input int len, input int bub);
        bit got;
        for (int b = 0; b < len; b++) begin
            if (b == bub) begin wr_valid = 0; cycle(); end
            wr_data = rnd_data();
            wr_valid = 1;
            wq.push_back(wr_data);
            got = 0;
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (amm_ready_0) begin got = 1; break; end
            end
            cycle();
            if (!got) begin
                n_tests++; n_fail++;
                $display("FAIL wbeat_timeout: beat %0d stalled", b);
                wr_valid = 0;
                return;
            end
        end
        wr_valid = 0;
    endtask

    task automatic wait_quiet();
        bit ok = 0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        cycle();
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL idle_timeout: busy never dropped");
        end
    endtask

    int c0, q0, e0, r0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk1("rel_ready0", cmd_ready, 1'b0);
        cycle();
        @(negedge clk);
        chk1("rel_ready1", cmd_ready, 1'b1);
        cycle();

        // write 4 @0x100, ready always high
        c0 = cnt_wbeat; q0 = cnt_req;
        send_cmd(1, 23'h100, 4);
        chkv("t1_addr", DW'(amm_address_0), DW'(23'h100));
        chkv("t1_bcount", DW'(amm_burstcount_0), DW'(4));
        wr_burst(4, -1);
        wait_quiet();
        chki("t1_beats", cnt_wbeat - c0, 4);
        chki("t1_req_cycles", cnt_req - q0, 4);

        // write 8 with two stall cycles and a bubble before beat 5
        c0 = cnt_wbeat; q0 = cnt_req;
        rdy_script = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        send_cmd(1, 23'h2345, 8);
        wr_burst(8, 4);
        wait_quiet();
        chki("t2_beats", cnt_wbeat - c0, 8);
        chki("t2_req_cycles", cnt_req - q0, 10);

        // read 16 with a hesitant controller
        r0 = cnt_rdv;
        rdy_pct = 30;
        send_cmd(0, 23'h7000, 16);
        wait_quiet();
        chki("t3_rd_beats", cnt_rdv - r0, 16);
        chk1("t3_idle", busy, 1'b0);

        // credit exhaustion: two reads of 64, third waits for returns
        rdy_pct = 100; ret_en = 0; r0 = cnt_rdv;
        send_cmd(0, 23'h10, 64);
        cycle();
        send_cmd(0, 23'h50, 64);
        cycle();
        chk1("t4_busy", busy, 1'b1);
        cmd_valid = 1; cmd_write = 0; cmd_len = 7'd64;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("t4_held", cmd_ready, 1'b0);
        end
        cycle();
        ret_en = 1;
        send_cmd(0, 23'h90, 64);
        wait_quiet();
        chki("t4_rd_beats", cnt_rdv - r0, 192);

        // illegal lengths
        e0 = cnt_err; q0 = cnt_req;
        send_cmd(1, 23'h33, 0);
        chk1("t5_err0", cmd_err, 1'b1);
        send_cmd(0, 23'h44, 65);
        chk1("t5_err65", cmd_err, 1'b1);
        repeat (3) cycle();
        chki("t5_err_count", cnt_err - e0, 2);
        chki("t5_no_traffic", cnt_req - q0, 0);

        // reset during beat 3 of a write of 8
        send_cmd(1, 23'h2a, 8);
        for (int b = 0; b < 2; b++) begin
            wr_data = rnd_data(); wr_valid = 1; wq.push_back(wr_data);
            cycle();
        end
        wr_data = rnd_data(); wr_valid = 1; wq.push_back(wr_data);
        #2;
        rst = 1;
        #1;
        chk1("t6_write", amm_write_0, 1'b0);
        chk1("t6_wr_ready", wr_ready, 1'b0);
        chk1("t6_busy", busy, 1'b0);
        chk1("t6_cmd_ready", cmd_ready, 1'b0);
        chkv("t6_addr", DW'(amm_address_0), '0);
        chkv("t6_bcount", DW'(amm_burstcount_0), '0);
        wr_valid = 0;
        cycle();
        cycle();
        rst = 0;
        cycle();
        c0 = cnt_wbeat;
        send_cmd(1, 23'h40, 2);
        wr_burst(2, -1);
        wait_quiet();
        chki("t6_after_beats", cnt_wbeat - c0, 2);

        // random mix
        rdy_pct = 70;
        for (int n = 0; n < 40; n++) begin
            bit w = 1'($urandom_range(1));
            int len;
            if ($urandom_range(9) == 0)
                len = ($urandom_range(1) == 0) ? 0 : $urandom_range(127, 65);
            else
                len = $urandom_range(64, 1);
            send_cmd(w, AW'($urandom()), len);
            if (w && len >= 1 && len <= 64)
                wr_burst(len, ($urandom_range(2) == 0) ?
                              $urandom_range(len - 1) : -1);
            if ($urandom_range(4) == 0) wait_quiet();
        end
        wait_quiet();
        chk1("t7_idle", busy, 1'b0);
        chki("t7_wq_empty", wq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/ddr3_amm_burst_master.md
# ddr3_amm_burst_master

Avalon-MM burst master that drives the `ctrl_amm_0` port of the DDR3 EMIF. It accepts read/write burst commands from user logic, streams write data into the controller, and returns read data. Flow control is through a read-credit counter. The block sits in the `emif_usr_clk` domain, between the fiber-side buffering logic and the EMIF.

## Interface

Parameters:
- `ADDR_W`, default 23: Avalon word-address width.
- `DATA_W`, default 320: data width.
- `BURST_W`, default 7: burstcount width.
- `MAX_BURST`, default 64: largest legal burst length in beats.
- `RD_CREDITS`, default 128: read beats allowed in flight; equals the depth of the downstream read FIFO.

Ports:
- `emif_usr_clk` in 1: the single clock, taken from the EMIF user clock.
- `emif_usr_rst` in 1: reset, asynchronous and active-high (inverted `emif_usr_reset_n`).
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in ADDR_W: start word address.
- `cmd_len` in BURST_W: burst length in beats, legal range 1..MAX_BURST.
- `wr_data` in DATA_W: write beat.
- `wr_valid` in 1: write beat offered.
- `wr_ready` out 1: write beat consumed when both `wr_valid` and `wr_ready` are high.
- `rd_data` out DATA_W: read beat, registered.
- `rd_valid` out 1: read beat valid. No backpressure; the downstream FIFO is sized by credits.
- `cmd_err` out 1: one-cycle pulse when an illegal length is dropped.
- `busy` out 1: high when the block is not idle or read credits are outstanding.
- `amm_ready_0` in 1: EMIF `waitrequest_n`.
- `amm_read_0` out 1: Avalon read request.
- `amm_write_0` out 1: Avalon write request.
- `amm_address_0` out ADDR_W: Avalon address.
- `amm_burstcount_0` out BURST_W: Avalon burstcount.
- `amm_writedata_0` out DATA_W: Avalon write data.
- `amm_byteenable_0` out DATA_W/8: Avalon byte enables.
- `amm_readdata_0` in DATA_W: Avalon read data.
- `amm_readdatavalid_0` in 1: Avalon read data valid.

## Operation

- State machine states: IDLE, WR_BURST, RD_REQ.
- IDLE:
  - `cmd_ready` = 1 only if `cmd_write` = 1, or `credits_free` >= `cmd_len`.
  - An accepted command with `cmd_len` = 0 or `cmd_len` > MAX_BURST is dropped. `cmd_err` pulses on the next cycle and the state stays IDLE.
  - An accepted legal command latches address and length into `amm_address_0` and `amm_burstcount_0`, which hold until the burst ends.
  - A write command goes to WR_BURST; a read command goes to RD_REQ.
- WR_BURST:
  - `amm_write_0` = `wr_valid`.
  - `amm_writedata_0` = `wr_data` (combinational pass-through).
  - `wr_ready` = `amm_ready_0`.
  - A beat completes when `wr_valid` and `amm_ready_0` are both high; each completed beat decrements the beat counter.
  - Bubbles are allowed: `wr_valid` may go low mid-burst, and `amm_write_0` follows it.
  - After the last beat completes, the state returns to IDLE on the next cycle.
- RD_REQ:
  - `amm_read_0` = 1 and is held until `amm_ready_0` = 1.
  - On that cycle, `outstanding` += `cmd_len` and the state returns to IDLE.
- Read return:
  - Each `amm_readdatavalid_0` decrements `outstanding` by 1.
  - `rd_data` and `rd_valid` are registered copies of `amm_readdata_0` and `amm_readdatavalid_0`.
- Credit arithmetic:
  - `credits_free` = RD_CREDITS − `outstanding`.
  - `outstanding` is log2(RD_CREDITS)+1 bits wide.
  - A simultaneous increment and decrement in one cycle nets to +`len`−1.
  - An underflow (readdatavalid while `outstanding` = 0) is a simulation assertion; in hardware the counter saturates at 0.
- `amm_byteenable_0` is constant all-ones.
- `amm_read_0` and `amm_write_0` are never high together.
- `wr_ready` = 0 outside WR_BURST.

## Timing

- Reset values (asynchronous): state IDLE; `amm_read_0`, `amm_write_0`, `rd_valid`, `cmd_err`, `busy`, `cmd_ready` = 0; `amm_address_0`, `amm_burstcount_0`, `rd_data`, `outstanding` = 0. `cmd_ready` is released on the first clock after reset.
- Command acceptance: the first write beat can be presented on the cycle after acceptance; the read request likewise appears on the cycle after acceptance.
- Back-to-back commands: minimum one IDLE cycle between bursts.
- Read data latency: `rd_valid` follows `amm_readdatavalid_0` by exactly 1 cycle.
- Reset mid-burst: the block aborts to IDLE, and all in-flight state is discarded. The EMIF is reset by the same source, so no cleanup handshake is needed.

## Structure

- Package `ddr3_amm_pkg` holds:
  - widths `ADDR_W`, `DATA_W`, `BURST_W`, `BE_W`;
  - `MAX_BURST`;
  - the state enum `amm_state_t` (IDLE, WR_BURST, RD_REQ).
- One sub-module, `ddr3_rd_credit`: the outstanding/credit counter, with add-len, sub-one, saturate and `credits_free` output.

## Test plan

- Write burst, `cmd_len` = 4 at address 0x100, `amm_ready_0` always 1: exactly 4 `amm_write_0` beats, `amm_address_0` = 0x100 and burstcount = 4 held throughout, then IDLE.
- Write burst, length 8, with `amm_ready_0` deasserted on beats 2–3 and a `wr_valid` bubble on beat 5: 8 beats transferred in order, no beat lost or duplicated, `wr_ready` tracks `amm_ready_0`.
- Read burst, length 16: `amm_read_0` held until `amm_ready_0`; 16 `amm_readdatavalid_0` beats yield 16 `rd_valid` beats, each 1 cycle later with matching data; `outstanding` ends at 0.
- RD_CREDITS = 128: two reads of 64 are accepted; a third read is held off (`cmd_ready` = 0) until one beat returns... more precisely, it is accepted only once `credits_free` >= 64; a simultaneous issue and return updates `outstanding` correctly.
- `cmd_len` = 0 and `cmd_len` = 65: each is consumed with a one-cycle `cmd_err` pulse and no Avalon activity.
- Assert `emif_usr_rst` during beat 3 of a write of 8: all outputs go to their reset values immediately; a fresh write of 2 afterwards completes normally.
